// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced active-low decoder family.
package decoder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StGap
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefOutW  = 2 ** DefAddrW;

  // Active-low one-hot of the original 5-to-32 decoder.
  function automatic logic [DefOutW-1:0] onehot_n(input logic [DefAddrW-1:0] addr);
    return ~(DefOutW'(1) << addr);
  endfunction

endpackage

// File: rtl/decoder_onehot_n.sv
// Combinational ADDR_W-to-2**ADDR_W active-low one-hot decode.
module decoder_onehot_n
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  localparam int unsigned OUT_W = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [OUT_W-1:0]  y_n_o
);

  if (ADDR_W == DefAddrW) begin : g_legacy
    assign y_n_o = onehot_n(addr_i);
  end else begin : g_generic
    assign y_n_o = ~(OUT_W'(1) << addr_i);
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered active-low select driver: timed single-shot or wrapping scan pulses
// with break-before-make gaps between consecutive selects.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 1,
  localparam int unsigned OUT_W  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  output logic [OUT_W-1:0]  y_n,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PulseCntW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int unsigned GapCntW   = (GAP_W > 1) ? $clog2(GAP_W) : 1;
  localparam int unsigned GapLast   = (GAP_W > 0) ? GAP_W - 1 : 0;

  state_e                 state_q, state_d;
  logic [PulseCntW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [GapCntW-1:0]     gap_cnt_q, gap_cnt_d;
  logic                   mode_q, mode_d;
  logic [ADDR_W-1:0]      end_q, end_d;
  logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
  logic [OUT_W-1:0]       y_n_q, y_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   drive_d;
  logic [OUT_W-1:0]       dec_n;

  assign start_ready = (state_q == StIdle) && en;

  decoder_onehot_n #(
    .ADDR_W(ADDR_W)
  ) u_dec (
    .addr_i(cur_addr_d),
    .y_n_o (dec_n)
  );

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    mode_d      = mode_q;
    end_d       = end_q;
    cur_addr_d  = cur_addr_q;
    drive_d     = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_valid && start_ready) begin
          state_d     = StAssert;
          mode_d      = mode;
          end_d       = addr_end;
          cur_addr_d  = addr_start;
          pulse_cnt_d = '0;
          drive_d     = 1'b1;
        end
      end
      StAssert: begin
        if (!en) begin
          state_d = StIdle;
        end else if (pulse_cnt_q == PulseCntW'(PULSE_W - 1)) begin
          if (mode_q == MODE_SINGLE || cur_addr_q == end_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (GAP_W > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            // Back-to-back: next select goes low on the very next cycle.
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            pulse_cnt_d = '0;
            drive_d     = 1'b1;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q + PulseCntW'(1);
          drive_d     = 1'b1;
        end
      end
      StGap: begin
        if (!en) begin
          state_d = StIdle;
        end else if (gap_cnt_q == GapCntW'(GapLast)) begin
          state_d     = StAssert;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          pulse_cnt_d = '0;
          drive_d     = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GapCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    y_n_d  = drive_d ? dec_n : '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      mode_q      <= MODE_SINGLE;
      end_q       <= '0;
      cur_addr_q  <= '0;
      y_n_q       <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      mode_q      <= mode_d;
      end_q       <= end_d;
      cur_addr_q  <= cur_addr_d;
      y_n_q       <= y_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign y_n      = y_n_q;
  assign cur_addr = cur_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed plus randomized bench for decoder_seq against a cycle-trace model.
module tb_decoder_seq;

  localparam int AW = 5;
  localparam int NOUT = 32;
  localparam int PW = 4;
  localparam int GW = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            mode;
  logic            start_valid;
  logic            start_ready;
  logic [AW-1:0]   addr_start;
  logic [AW-1:0]   addr_end;
  logic [NOUT-1:0] y_n;
  logic [AW-1:0]   cur_addr;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_y[$];
  logic [31:0] exp_addr[$];
  logic        exp_busy[$];
  logic        exp_done[$];

  decoder_seq #(
    .ADDR_W (AW),
    .PULSE_W(PW),
    .GAP_W  (GW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .y_n        (y_n),
    .cur_addr   (cur_addr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sel_n(input int a);
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    v[a] = 1'b0;
    return v;
  endfunction

  // Expected per-cycle outputs from the cycle after acceptance through the done cycle.
  task automatic build_trace(input logic m, input int as, input int ae);
    int a;
    exp_y.delete(); exp_addr.delete(); exp_busy.delete(); exp_done.delete();
    a = as;
    forever begin
      for (int i = 0; i < PW; i++) begin
        exp_y.push_back(sel_n(a)); exp_addr.push_back(a);
        exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
      end
      if (m == 1'b0 || a == ae) break;
      for (int i = 0; i < GW; i++) begin
        exp_y.push_back(32'hFFFF_FFFF); exp_addr.push_back(a);
        exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
      end
      a = (a + 1) % NOUT;
    end
    exp_y.push_back(32'hFFFF_FFFF); exp_addr.push_back(a);
    exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] a);
    chk({tag, ".y_n"}, y_n, 32'hFFFF_FFFF);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".cur_addr"}, 32'(cur_addr), a);
  endtask

  // Called just after a posedge with en=1 and the DUT idle.
  task automatic run_op(input string tag, input logic m, input int as, input int ae,
                        input int abort_at, input bit hold, input int hold_a);
    int len;
    build_trace(m, as, ae);
    len = (abort_at >= 0) ? abort_at + 1 : exp_y.size();
    mode = m; addr_start = AW'(as); addr_end = AW'(ae); start_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      mode = 1'b0; addr_start = AW'(hold_a);
    end else begin
      start_valid = 1'b0; mode = ~m;
      addr_start = AW'($urandom); addr_end = AW'($urandom);
    end
    for (int c = 0; c < len; c++) begin
      if (c == abort_at) en = 1'b0;
      @(negedge clk);
      chk({tag, ".y_n"}, y_n, exp_y[c]);
      chk({tag, ".cur_addr"}, 32'(cur_addr), exp_addr[c]);
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy[c]));
      chk({tag, ".done"}, 32'(done), 32'(exp_done[c]));
      chk({tag, ".onehot"}, 32'($countones(~y_n) <= 1), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    if (hold) begin
      chk({tag, ".held_busy"}, 32'(busy), 32'd1);
      chk({tag, ".held_addr"}, 32'(cur_addr), 32'(hold_a));
      chk({tag, ".held_y_n"}, y_n, sel_n(hold_a));
    end else begin
      check_idle({tag, ".after"}, (abort_at >= 0) ? exp_addr[abort_at] : exp_addr[len-1]);
      chk({tag, ".ready_after"}, 32'(start_ready), 32'(en));
    end
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; start_valid = 1'b0;
    addr_start = '0; addr_end = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset", 32'd0);
    chk("reset.start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;

    run_op("single3", 1'b0, 3, 3, -1, 1'b0, 0);
    run_op("scan5_7", 1'b1, 5, 7, -1, 1'b0, 0);
    run_op("wrap30_1", 1'b1, 30, 1, -1, 1'b0, 0);
    run_op("scan_eq", 1'b1, 12, 12, -1, 1'b0, 0);
    run_op("wrap31_0", 1'b1, 31, 0, -1, 1'b0, 0);
    run_op("single_ign_end", 1'b0, 9, 20, -1, 1'b0, 0);
    // Second pulse cycle of address 31 in a 30->1 scan.
    run_op("abort31", 1'b1, 30, 1, PW + GW + 1, 1'b0, 0);
    chk("abort31.addr", 32'(cur_addr), 32'd31);
    run_op("abort_gap", 1'b1, 2, 6, PW, 1'b0, 0);

    // Disabled while idle: no acceptance.
    en = 1'b0; start_valid = 1'b1; addr_start = AW'(4);
    @(negedge clk);
    chk("en_low.start_ready", 32'(start_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("en_low.busy", 32'(busy), 32'd0);
    chk("en_low.y_n", y_n, 32'hFFFF_FFFF);
    start_valid = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      run_op("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, NOUT - 1)),
             int'($urandom_range(0, NOUT - 1)), -1, 1'b0, 0);
    end

    // Request held across a scan is only taken at the done cycle; then reset mid-pulse.
    run_op("hold", 1'b1, 20, 22, -1, 1'b1, 17);
    start_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("midreset", 32'd0);
    chk("midreset.start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    run_op("post_reset", 1'b1, 0, 2, -1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
